apb_rr_master: RTL and testbench

- APB master that shares one APB bus between two requesters, arbitrated round-robin.
- Each requester hands over a single read or write; the block runs the APB SETUP/ACCESS sequence, waits on PREADY, then returns a one-cycle response to the owner.
- Sits in front of the RAM memory slave (slave 0) and any other APB slaves on the same PSEL line.

---
 rtl/apb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 25 ++
 rtl/apb_rr_master.sv | 178 +++++++++++++++++
 tb/tb_apb_rr_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB round-robin master: FSM encoding and default widths.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, registered last-grant pointer.
module rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] valid,
  input  logic       gnt_en,
  output logic       winner
);

  logic last_gnt;

  // With both requesting, the one not granted last wins; otherwise the lone requester.
  always_comb begin
    winner = (valid == 2'b11) ? ~last_gnt : valid[1];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_gnt <= 1'b1;
    end else if (gnt_en) begin
      last_gnt <= winner;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by two requesters with round-robin arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                  PCLK,
  input  logic                                  PRESET,
  input  logic [1:0]                            REQ_VALID,
  input  logic [1:0]                            REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0]               REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0]               REQ_WDATA,
  input  logic [2*strb_width(DATA_WIDTH)-1:0]   REQ_STRB,
  output logic [1:0]                            REQ_GNT,
  output logic [1:0]                            RSP_VALID,
  output logic [DATA_WIDTH-1:0]                 RSP_RDATA,
  output logic                                  RSP_ERR,
  output logic                                  PSEL,
  output logic                                  PENABLE,
  output logic                                  PWRITE,
  output logic [ADDR_WIDTH-1:0]                 PADDR,
  output logic [DATA_WIDTH-1:0]                 PWDATA,
  output logic [strb_width(DATA_WIDTH)-1:0]     PSTRB,
  input  logic                                  PREADY,
  input  logic [DATA_WIDTH-1:0]                 PRDATA
);

  localparam int SW = strb_width(DATA_WIDTH);

  if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_rr_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_t state, state_n;

  logic                  psel, psel_n, penable, penable_n, pwrite, pwrite_n;
  logic [ADDR_WIDTH-1:0] paddr, paddr_n;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_n;
  logic [SW-1:0]         pstrb, pstrb_n;
  logic                  owner, owner_n;
  logic [1:0]            gnt, gnt_n, rsp_valid, rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_rdata, rsp_rdata_n;
  logic                  gnt_en, win;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic          rsp_err, rsp_err_n;
`endif

  rr_arb2 u_arb (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .valid  (REQ_VALID),
    .gnt_en (gnt_en),
    .winner (win)
  );

  always_comb begin
    state_n     = state;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    pstrb_n     = pstrb;
    owner_n     = owner;
    gnt_n       = '0;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata;
    gnt_en      = 1'b0;
`ifdef APB_TIMEOUT_EN
    tcnt_n      = tcnt;
    rsp_err_n   = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (|REQ_VALID) begin
          gnt_en     = 1'b1;
          owner_n    = win;
          gnt_n[win] = 1'b1;
          psel_n     = 1'b1;
          penable_n  = 1'b0;
          pwrite_n   = REQ_WRITE[win];
          paddr_n    = REQ_ADDR[win*ADDR_WIDTH +: ADDR_WIDTH];
          // Reads drive zero write data and strobes onto the bus.
          pwdata_n   = REQ_WRITE[win] ? REQ_WDATA[win*DATA_WIDTH +: DATA_WIDTH] : '0;
          pstrb_n    = REQ_WRITE[win] ? REQ_STRB[win*SW +: SW] : '0;
          state_n    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_n = 1'b1;
        state_n   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        tcnt_n    = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_n             = 1'b0;
          penable_n          = 1'b0;
          rsp_valid_n[owner] = 1'b1;
          rsp_rdata_n        = pwrite ? '0 : PRDATA;
          state_n            = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          psel_n             = 1'b0;
          penable_n          = 1'b0;
          rsp_valid_n[owner] = 1'b1;
          rsp_rdata_n        = '0;
          rsp_err_n          = 1'b1;
          state_n            = ST_IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      owner     <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      tcnt      <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      pstrb     <= pstrb_n;
      owner     <= owner_n;
      gnt       <= gnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
`ifdef APB_TIMEOUT_EN
      tcnt      <= tcnt_n;
      rsp_err   <= rsp_err_n;
`endif
    end
  end

  assign REQ_GNT   = gnt;
  assign RSP_VALID = rsp_valid;
  assign RSP_RDATA = rsp_rdata;
  assign PSEL      = psel;
  assign PENABLE   = penable;
  assign PWRITE    = pwrite;
  assign PADDR     = paddr;
  assign PWDATA    = pwdata;
  assign PSTRB     = pstrb;
`ifdef APB_TIMEOUT_EN
  assign RSP_ERR   = rsp_err;
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: APB slave model, per-requester expected-response queues.
module tb_apb_rr_master;
  localparam int DW = 32, AW = 32, SW = DW / 8;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [1:0]      REQ_VALID, REQ_WRITE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [2*SW-1:0] REQ_STRB;
  logic [1:0]      REQ_GNT, RSP_VALID;
  logic [DW-1:0]   RSP_RDATA;
  logic            RSP_ERR;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic            PREADY;
  logic [DW-1:0]   PRDATA;

  int tests = 0;
  int fails = 0;

  always #5 PCLK = ~PCLK;

  apb_rr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB), .REQ_GNT(REQ_GNT),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  // Slave memory and an independent reference copy used for expectations
  logic [DW-1:0] smem    [0:63];
  logic [DW-1:0] ref_mem [0:63];
  int wait_cfg = 0;
  int acc_cnt  = 0;
  bit stuck    = 0;

  always @(negedge PCLK) begin
    PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= wait_cfg);
    PRDATA = smem[PADDR[7:2]];
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PRESET) begin
      if (PREADY) begin
        acc_cnt = 0;
        if (PWRITE)
          for (int b = 0; b < SW; b++)
            if (PSTRB[b]) smem[PADDR[7:2]][b*8 +: 8] = PWDATA[b*8 +: 8];
      end else begin
        acc_cnt++;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // Requesters withdraw REQ_VALID once their grant pulse is seen
  always @(posedge PCLK) begin
    #2;
    for (int i = 0; i < 2; i++)
      if (REQ_GNT[i] === 1'b1) REQ_VALID[i] = 1'b0;
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic drive_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_t e;
    REQ_WRITE[i]            = w;
    REQ_ADDR[i*AW +: AW]    = a;
    REQ_WDATA[i*DW +: DW]   = d;
    REQ_STRB[i*SW +: SW]    = s;
    REQ_VALID[i]            = 1'b1;
    e.err = 1'b0;
    if (w) begin
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
      e.rdata = '0;
    end else begin
      e.rdata = ref_mem[a[7:2]];
    end
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_rsp(input int maxc, output logic [1:0] v, output logic [DW-1:0] d,
                          output logic er, output int cyc);
    cyc = 0; v = '0; d = '0; er = 1'b0;
    while (cyc < maxc) begin
      @(negedge PCLK);
      cyc++;
      if (RSP_VALID !== 2'b00) begin
        v = RSP_VALID; d = RSP_RDATA; er = RSP_ERR;
        return;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (n) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    tests++;
    if ({REQ_GNT, RSP_VALID, RSP_RDATA, RSP_ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== '0)
      begin fails++; $display("FAIL reset_outputs: got gnt=%b rsp=%b psel=%b pen=%b paddr=%h want all 0",
                              REQ_GNT, RSP_VALID, PSEL, PENABLE, PADDR); end
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      tests++;
      if (PSEL !== 1'b0) begin fails++; $display("FAIL idle_psel: got %b want 0", PSEL); end
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    logic [1:0] v; logic [DW-1:0] d; logic er; int cyc;
    @(negedge PCLK);
    drive_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge PCLK);
    tests++;
    if ({REQ_GNT, PSEL, PENABLE, PWRITE} !== 5'b01_1_0_1)
      begin fails++; $display("FAIL wr_setup_ctrl: got %b want 01101", {REQ_GNT, PSEL, PENABLE, PWRITE}); end
    tests++;
    if ({PADDR, PWDATA, PSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF})
      begin fails++; $display("FAIL wr_setup_bus: got %h %h %h want 10 deadbeef f", PADDR, PWDATA, PSTRB); end
    @(negedge PCLK);
    tests++;
    if ({REQ_GNT, PSEL, PENABLE, RSP_VALID} !== 6'b00_1_1_00)
      begin fails++; $display("FAIL wr_access_ctrl: got %b want 001100", {REQ_GNT, PSEL, PENABLE, RSP_VALID}); end
    @(negedge PCLK);
    tests++;
    if ({RSP_VALID, PSEL, PENABLE} !== 4'b01_0_0)
      begin fails++; $display("FAIL wr_rsp_ctrl: got %b want 0100", {RSP_VALID, PSEL, PENABLE}); end
    e = q0.pop_front();
    tests++;
    if (RSP_RDATA !== e.rdata || RSP_ERR !== e.err)
      begin fails++; $display("FAIL wr_rsp_data: got %h err=%b want %h err=%b", RSP_RDATA, RSP_ERR, e.rdata, e.err); end
    @(negedge PCLK);
    drive_req(0, 1'b0, 32'h10, '0, '0);
    wait_rsp(10, v, d, er, cyc);
    e = q0.pop_front();
    tests++;
    if (v !== 2'b01 || d !== e.rdata || d !== 32'hDEADBEEF || cyc != 3)
      begin fails++; $display("FAIL rd_back: got v=%b d=%h cyc=%0d want v=01 d=%h cyc=3", v, d, cyc, e.rdata); end
  endtask

  task automatic test_wait_states();
    exp_t e;
    logic [AW-1:0] a0; logic ctl0; int acc; bit stable;
    wait_cfg = 2;
    @(negedge PCLK);
    drive_req(0, 1'b0, 32'h04, '0, '0);
    @(negedge PCLK);
    a0 = PADDR; ctl0 = PWRITE; acc = 0; stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 2'b00) break;
      if (PSEL === 1'b1 && PENABLE === 1'b1) acc++;
      if (PADDR !== a0 || PWRITE !== ctl0 || PSEL !== 1'b1 || PENABLE !== 1'b1 || PSTRB !== '0) stable = 0;
    end
    tests++;
    if (acc != 3 || !stable || a0 !== 32'h04)
      begin fails++; $display("FAIL wait_access: got cycles=%0d stable=%0d addr=%h want 3 1 4", acc, stable, a0); end
    e = q0.pop_front();
    tests++;
    if (RSP_VALID !== 2'b01 || RSP_RDATA !== e.rdata || RSP_RDATA !== 32'h12345678)
      begin fails++; $display("FAIL wait_rsp: got v=%b d=%h want v=01 d=12345678", RSP_VALID, RSP_RDATA); end
    wait_cfg = 0;
  endtask

  task automatic test_arbitration();
    int n[2]; int ngnt, nrsp, exp_gnt, k;
    exp_t e;
    do_reset(1);
    n[0] = 4; n[1] = 4; ngnt = 0; nrsp = 0; exp_gnt = 0;
    for (int cyc = 0; cyc < 200 && nrsp < 8; cyc++) begin
      @(negedge PCLK);
      for (int i = 0; i < 2; i++) begin
        if (REQ_GNT[i] === 1'b1) begin
          ngnt++;
          tests++;
          if (i != exp_gnt) begin fails++; $display("FAIL arb_order: got %0d want %0d", i, exp_gnt); end
          exp_gnt = 1 - i;
        end
        if (RSP_VALID[i] === 1'b1) begin
          nrsp++;
          tests++;
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            fails++; $display("FAIL arb_rsp_unexpected: got rsp for %0d want none", i);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (RSP_RDATA !== e.rdata)
              begin fails++; $display("FAIL arb_rsp_data: got %h want %h (req %0d)", RSP_RDATA, e.rdata, i); end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (REQ_VALID[i] === 1'b0 && n[i] > 0) begin
          k = 4 - n[i];
          drive_req(i, k < 2, 32'h80 + 32'(i) * 32'h20 + 32'(k % 2) * 4,
                    {8'hA0 + 8'(i), 8'(k), 16'h5A5A}, 4'hF);
          n[i]--;
        end
      end
    end
    tests++;
    if (ngnt != 8 || nrsp != 8 || q0.size() != 0 || q1.size() != 0)
      begin fails++; $display("FAIL arb_count: got gnt=%0d rsp=%0d left=%0d want 8 8 0", ngnt, nrsp, q0.size() + q1.size()); end
  endtask

  task automatic test_strobe_read();
    exp_t e;
    logic [1:0] v; logic [DW-1:0] d; logic er; int cyc;
    @(negedge PCLK);
    drive_req(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'h3);
    @(negedge PCLK);
    tests++;
    if (PSTRB !== 4'h3 || PWRITE !== 1'b1)
      begin fails++; $display("FAIL strb_write: got strb=%h wr=%b want 3 1", PSTRB, PWRITE); end
    wait_rsp(10, v, d, er, cyc);
    void'(q1.pop_front());
    @(negedge PCLK);
    drive_req(1, 1'b0, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(negedge PCLK);
    tests++;
    if (PSTRB !== 4'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0)
      begin fails++; $display("FAIL read_zero_bus: got strb=%h wdata=%h wr=%b want 0 0 0", PSTRB, PWDATA, PWRITE); end
    wait_rsp(10, v, d, er, cyc);
    e = q1.pop_front();
    tests++;
    if (v !== 2'b10 || d !== e.rdata)
      begin fails++; $display("FAIL strb_readback: got v=%b d=%h want 10 %h", v, d, e.rdata); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [1:0] v; logic [DW-1:0] d; logic er; int cyc; bit quiet;
    stuck = 1;
    @(negedge PCLK);
    drive_req(0, 1'b0, 32'h08, '0, '0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    tests++;
    if ({PSEL, PENABLE, RSP_VALID, REQ_GNT} !== '0)
      begin fails++; $display("FAIL midreset_bus: got psel=%b pen=%b rsp=%b want 0 0 00", PSEL, PENABLE, RSP_VALID); end
    PRESET = 1'b0;
    stuck = 0;
    void'(q0.pop_back());
    quiet = 1;
    repeat (4) begin
      @(negedge PCLK);
      if (RSP_VALID !== 2'b00 || PSEL !== 1'b0) quiet = 0;
    end
    tests++;
    if (!quiet) begin fails++; $display("FAIL midreset_quiet: got activity want none"); end
    drive_req(1, 1'b0, 32'h14, '0, '0);
    drive_req(0, 1'b0, 32'h18, '0, '0);
    @(negedge PCLK);
    tests++;
    if (REQ_GNT !== 2'b01) begin fails++; $display("FAIL midreset_ptr: got %b want 01", REQ_GNT); end
    wait_rsp(10, v, d, er, cyc);
    e = q0.pop_front();
    tests++;
    if (v !== 2'b01 || d !== e.rdata) begin fails++; $display("FAIL ptr_rsp0: got %b %h want 01 %h", v, d, e.rdata); end
    wait_rsp(10, v, d, er, cyc);
    e = q1.pop_front();
    tests++;
    if (v !== 2'b10 || d !== e.rdata) begin fails++; $display("FAIL ptr_rsp1: got %b %h want 10 %h", v, d, e.rdata); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    stuck = 1;
    @(negedge PCLK);
    drive_req(1, 1'b0, 32'h0C, '0, '0);
    void'(q1.pop_front());
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 2'b00) break;
      if (PSEL === 1'b1 && PENABLE === 1'b1) acc++;
    end
    tests++;
    if (acc != 16 || RSP_VALID !== 2'b10 || RSP_ERR !== 1'b1 || RSP_RDATA !== '0 || PSEL !== 1'b0)
      begin fails++; $display("FAIL timeout: got cycles=%0d v=%b err=%b d=%h want 16 10 1 0", acc, RSP_VALID, RSP_ERR, RSP_RDATA); end
    stuck = 0;
  endtask
`endif

  initial begin
    PRESET = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_STRB = '0;
    PREADY = 1'b0; PRDATA = '0;
    for (int i = 0; i < 64; i++) begin
      smem[i]    = 32'hA5000000 | 32'(i * 32'h01010);
      ref_mem[i] = smem[i];
    end
    smem[1] = 32'h12345678; ref_mem[1] = 32'h12345678;
    test_reset();
    test_single_write();
    test_wait_states();
    test_arbitration();
    test_strobe_read();
    test_mid_reset();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
